// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared types for the host-requestor read arbiter
package hc_pkg;

    localparam int HC_ARB_NUM_REQ = 4;

    typedef enum logic [2:0] {
        e_REQUEST_NONE          = 3'd0,
        e_REQUEST_READ_STREAM   = 3'd1,
        e_REQUEST_READ_INDEXED  = 3'd2,
        e_REQUEST_WRITE_STREAM  = 3'd3,
        e_REQUEST_WRITE_INDEXED = 3'd4
    } t_request_cmd;

    typedef struct packed {
        t_request_cmd cmd;
        logic [7:0]   id;
        logic [31:0]  offset;
    } t_request_control;

    typedef enum logic [1:0] {
        S_ARB_IDLE  = 2'd0,
        S_ARB_GRANT = 2'd1,
        S_ARB_LOCK  = 2'd2
    } t_arb_state;

    // Value driven toward the read-request queue when nothing is issued
    localparam t_request_control REQ_CTRL_IDLE = '{cmd: e_REQUEST_NONE, id: 8'h00, offset: 32'h0};

    // Only the two read flavours may be forwarded to the read-request queue
    function automatic logic is_read_cmd(input t_request_cmd cmd);
        return (cmd == e_REQUEST_READ_STREAM) || (cmd == e_REQUEST_READ_INDEXED);
    endfunction

endpackage

// File: rtl/hc_rr_pick.sv
// rtl/hc_rr_pick.sv - combinational round-robin picker: first eligible requester at or after ptr
module hc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int pos;

    // Scan N positions starting at ptr, wrapping, and keep the first eligible one
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && valid[pos] && mask[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/hc_read_arbiter.sv
// rtl/hc_read_arbiter.sv - round-robin read-command arbiter with burst lock (optional HC_ARB_STATS_EN grant counters)
module hc_read_arbiter
    import hc_pkg::*;
#(
    parameter int NUM_REQ  = HC_ARB_NUM_REQ,
    parameter int HOLD_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  t_request_control           req_ctrl [NUM_REQ],
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output t_request_control           out_ctrl,
    input  logic                       out_full,
    output logic                       busy,
    output logic                       err_cmd,
    output logic [$clog2(NUM_REQ)-1:0] err_src
`ifdef HC_ARB_STATS_EN
    ,
    output logic [31:0]                grant_cnt [NUM_REQ]
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

    t_arb_state         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt, hold_inc;
    logic [NUM_REQ-1:0] pick_mask, pick_grant;
    logic [IDX_W-1:0]   pick_ptr, pick_idx;
    logic               pick_any;
    logic               xfer;
    logic               others;
    logic               win_lock;
    logic               win_legal;
    t_request_control   win_ctrl;

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // While locked only the owner is eligible; otherwise everyone, starting at rr_ptr
    always_comb begin
        pick_mask = '0;
        pick_ptr  = rr_ptr;
        if (state == S_ARB_LOCK) begin
            pick_mask[owner] = 1'b1;
            pick_ptr         = owner;
        end else begin
            pick_mask = '1;
        end
    end

    hc_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The registered full flag is trusted as-is: the queue keeps enough slack for its lag
    assign xfer      = pick_any & ~out_full;
    assign req_ready = xfer ? pick_grant : '0;
    assign win_ctrl  = req_ctrl[pick_idx];
    assign win_lock  = req_lock[pick_idx];
    assign win_legal = is_read_cmd(win_ctrl.cmd);
    assign others    = |(req_valid & ~pick_grant);
    assign hold_inc  = hold_cnt + CNT_W'(1);

    // Next-state: rotation, lock entry/exit and hold counting; nothing moves without a transfer
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_ARB_IDLE, S_ARB_GRANT: begin
                if (xfer) begin
                    if (win_lock && (HOLD_MAX > 1)) begin
                        state_nxt    = S_ARB_LOCK;
                        owner_nxt    = pick_idx;
                        hold_cnt_nxt = CNT_W'(1);
                    end else begin
                        rr_ptr_nxt = ptr_after(pick_idx);
                        state_nxt  = others ? S_ARB_GRANT : S_ARB_IDLE;
                    end
                end
            end
            S_ARB_LOCK: begin
                // An owner that drops valid simply stalls the lock; there is no timeout
                if (xfer) begin
                    if (!win_lock || (hold_inc == HOLD_LIMIT)) begin
                        state_nxt    = S_ARB_GRANT;
                        rr_ptr_nxt   = ptr_after(owner);
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_inc;
                    end
                end
            end
            default: begin
                state_nxt = S_ARB_IDLE;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Forward an accepted read for exactly one cycle; illegal commands are swallowed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ctrl <= REQ_CTRL_IDLE;
        end else if (xfer && win_legal) begin
            out_ctrl <= win_ctrl;
        end else begin
            out_ctrl <= REQ_CTRL_IDLE;
        end
    end

    // Sticky illegal-command flag; the source of the first offender is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cmd <= 1'b0;
            err_src <= '0;
        end else if (xfer && !win_legal) begin
            err_cmd <= 1'b1;
            if (!err_cmd) begin
                err_src <= pick_idx;
            end
        end
    end

    assign busy = (state == S_ARB_LOCK) | (out_ctrl.cmd != e_REQUEST_NONE);

`ifdef HC_ARB_STATS_EN
    // Per-requester count of forwarded reads, free-running with natural wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (xfer && win_legal) begin
            grant_cnt[pick_idx] <= grant_cnt[pick_idx] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hc_read_arbiter.sv
// tb/tb_hc_read_arbiter.sv - self-checking bench for hc_read_arbiter (vector table plus scoreboard)
module tb_hc_read_arbiter;
    import hc_pkg::*;

    localparam int N    = 4;
    localparam int HOLD = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_lock;
    logic [N-1:0]     req_ready;
    t_request_control req_ctrl [N];
    t_request_control out_ctrl;
    logic             out_full;
    logic             busy;
    logic             err_cmd;
    logic [1:0]       err_src;
`ifdef HC_ARB_STATS_EN
    logic [31:0]      grant_cnt [N];
`endif

    int tests = 0;
    int fails = 0;
    t_request_control sb_q[$];
    t_request_control sb_exp;

    typedef struct {
        logic [N-1:0] valid;
        logic         full;
        logic [N-1:0] ready;
    } vec_t;
    vec_t vt [12];

    always #5 clk = ~clk;

    hc_read_arbiter #(
        .NUM_REQ  (N),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ctrl  (req_ctrl),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .out_ctrl  (out_ctrl),
        .out_full  (out_full),
        .busy      (busy),
        .err_cmd   (err_cmd),
        .err_src   (err_src)
`ifdef HC_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every forwarded command must match the oldest expected one
    always @(negedge clk) begin
        if (!reset && out_ctrl.cmd != e_REQUEST_NONE) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got id %0h offset %0h, expected no output", out_ctrl.id, out_ctrl.offset);
            end else begin
                sb_exp = sb_q.pop_front();
                if (out_ctrl !== sb_exp) begin
                    fails++;
                    $display("FAIL out_ctrl: got %0h expected %0h", 64'(out_ctrl), 64'(sb_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic init_ctrl();
        for (int i = 0; i < N; i++) begin
            req_ctrl[i] = '{cmd: e_REQUEST_READ_STREAM, id: 8'(i), offset: 32'(i * 256)};
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        out_full  = 1'b0;
        init_ctrl();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One cycle: check req_ready mid-cycle, queue the reads that should go out, advance commands taken
    task automatic cycle(input logic [N-1:0] exp_ready);
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i] && (req_ctrl[i].cmd == e_REQUEST_READ_STREAM ||
                                 req_ctrl[i].cmd == e_REQUEST_READ_INDEXED)) begin
                sb_q.push_back(req_ctrl[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                req_ctrl[i].offset = req_ctrl[i].offset + 32'd1;
            end
        end
    endtask

    task automatic drain();
        req_valid = '0;
        cycle('0);
        cycle('0);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        vt[0]  = '{4'b0000, 1'b0, 4'b0000};
        vt[1]  = '{4'b1111, 1'b0, 4'b0001};
        vt[2]  = '{4'b1111, 1'b1, 4'b0000};
        vt[3]  = '{4'b1010, 1'b0, 4'b0010};
        vt[4]  = '{4'b1001, 1'b0, 4'b1000};
        vt[5]  = '{4'b0110, 1'b0, 4'b0010};
        vt[6]  = '{4'b0100, 1'b0, 4'b0100};
        vt[7]  = '{4'b0001, 1'b0, 4'b0001};
        vt[8]  = '{4'b0001, 1'b1, 4'b0000};
        vt[9]  = '{4'b1100, 1'b0, 4'b0100};
        vt[10] = '{4'b0111, 1'b0, 4'b0001};
        vt[11] = '{4'b0000, 1'b0, 4'b0000};

        // Reset state, held idle
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_cmd", 64'(out_ctrl.cmd), 64'(e_REQUEST_NONE));
            check("idle_ready", 64'(req_ready), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
        end
        check("rst_err_cmd", 64'(err_cmd), 64'(0));
        check("rst_err_src", 64'(err_src), 64'(0));
        @(posedge clk);
        #1;

        // Vector table: valid/full patterns against the rotating pointer
        for (int r = 0; r < 12; r++) begin
            req_valid = vt[r].valid;
            out_full  = vt[r].full;
            cycle(vt[r].ready);
            check("vec_busy", 64'(busy), 64'(vt[r].ready != '0));
        end
        out_full = 1'b0;
        drain();

        // Full rotation, first output one cycle after valid
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            cycle(4'b0001 << (k % 4));
            if (k == 0) begin
                check("t2_latency_cmd", 64'(out_ctrl.cmd), 64'(e_REQUEST_READ_STREAM));
                check("t2_latency_id", 64'(out_ctrl.id), 64'(0));
            end
        end
        drain();

        // Burst lock on requester 1, then normal rotation from 2
        do_reset();
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        cycle(4'b0010);
        req_valid = 4'b1111;
        cycle(4'b0010);
        cycle(4'b0010);
        req_lock = 4'b0000;
        cycle(4'b0010);
        cycle(4'b0100);
        cycle(4'b1000);
        cycle(4'b0001);
        cycle(4'b0010);
        drain();

        // Hold limit forces one grant to requester 3, then 2 relocks
        do_reset();
        req_valid = 4'b1100;
        req_lock  = 4'b0100;
        for (int k = 0; k < HOLD; k++) begin
            cycle(4'b0100);
        end
        cycle(4'b1000);
        cycle(4'b0100);
        req_valid = '0;
        repeat (3) cycle('0);
        check("t4_lock_busy", 64'(busy), 64'(1));
        check("t4_sb_empty", 64'(sb_q.size()), 64'(0));

        // Full stall mid-stream keeps the rotation order
        do_reset();
        req_valid = 4'b1111;
        cycle(4'b0001);
        cycle(4'b0010);
        out_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0000);
            check("t5_full_out", 64'(out_ctrl.cmd), 64'(e_REQUEST_NONE));
        end
        out_full = 1'b0;
        cycle(4'b0100);
        cycle(4'b1000);
        cycle(4'b0001);
        drain();

        // Illegal commands: consumed, flagged, first source kept
        do_reset();
        req_ctrl[0].cmd = e_REQUEST_WRITE_STREAM;
        req_valid       = 4'b0011;
        check("t6_err_before", 64'(err_cmd), 64'(0));
        cycle(4'b0001);
        check("t6_err_cmd", 64'(err_cmd), 64'(1));
        check("t6_err_src", 64'(err_src), 64'(0));
        check("t6_no_fwd", 64'(out_ctrl.cmd), 64'(e_REQUEST_NONE));
        req_ctrl[3].cmd = e_REQUEST_NONE;
        req_valid       = 4'b1010;
        cycle(4'b0010);
        cycle(4'b1000);
        check("t6_err_src_kept", 64'(err_src), 64'(0));
        check("t6_err_sticky", 64'(err_cmd), 64'(1));
        cycle(4'b0010);
        drain();
`ifdef HC_ARB_STATS_EN
        check("t6_cnt0", 64'(grant_cnt[0]), 64'(0));
        check("t6_cnt1", 64'(grant_cnt[1]), 64'(2));
        check("t6_cnt3", 64'(grant_cnt[3]), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
